sysbus_line_fetch: RTL and testbench

//  Parametrised Sysbus line-fill engine; successor of the single-line instruction fetch sequencer.

---
 rtl/sysbus_fetch_pkg.sv | 22 ++
 rtl/sysbus_line_fetch_line_assembler.sv | 40 ++++
 rtl/sysbus_line_fetch.sv | 131 +++++++++++++
 tb/tb_sysbus_line_fetch.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_fetch_pkg.sv
// Shared types and constants for the Sysbus line-fill engine.
package sysbus_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic        SYSBUS_READ   = 1'b1;
    localparam logic [3:0]  SYSBUS_MEMORY = 4'b0001;
    localparam logic [12:0] FETCH_REQTAG  = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

    // Clears the byte-offset bits of an address; line_bytes must be a power of two.
    function automatic logic [63:0] line_align(input logic [63:0] addr,
                                               input int unsigned line_bytes);
        return addr & ~(64'(line_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/sysbus_line_fetch_line_assembler.sv
// Beat counter and line buffer: counts response beats and optionally stores
// each one into its slot of the line.
module line_assembler #(
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 8,
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        beat_en,
    input  logic                        store_en,
    input  logic [BEAT_WIDTH-1:0]       beat_data,
    output logic [BEATS*BEAT_WIDTH-1:0] line,
    output logic                        last_beat
);

    logic [CNT_W-1:0] beat_cnt;

    assign last_beat = beat_en && (beat_cnt == CNT_W'(BEATS - 1));

    // A beat may be counted without being stored so the same counter serves
    // both normal collection and draining of an abandoned transfer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_cnt <= '0;
            line     <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (beat_en) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            for (int k = 0; k < BEATS; k++) begin
                if (store_en && beat_cnt == CNT_W'(k)) begin
                    line[k*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data;
                end
            end
        end
    end

endmodule

// File: rtl/sysbus_line_fetch.sv
// Sysbus line-fill engine: one READ/MEMORY request per line, response beats
// assembled into a line and handed to the fetch stage over valid/ready.
module sysbus_line_fetch
    import sysbus_fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int ADDR_WIDTH     = 64,
    parameter int LINE_BYTES     = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic                      flush,
    output logic                      line_valid,
    input  logic                      line_ready,
    output logic [ADDR_WIDTH-1:0]     line_addr,
    output logic [LINE_BYTES*8-1:0]   line_data,
    output logic                      busy,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int BEATS = LINE_BYTES * 8 / BUS_DATA_WIDTH;

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  reqcyc_q;
    logic                  line_valid_q;
    logic                  beat_en;
    logic                  store_en;
    logic                  clear;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] aligned_addr;
    logic                  unused_resptag;

    // Only one request is ever outstanding, so the response tag carries no information.
    assign unused_resptag = ^bus_resptag;

    assign aligned_addr = ADDR_WIDTH'(line_align(64'(req_addr), LINE_BYTES));
    assign beat_en      = bus_respcyc && (state == RESP || state == DRAIN);
    assign store_en     = (state == RESP) && !flush;
    assign clear        = (state == REQ) && bus_reqack;

    assign req_ready   = (state == IDLE) && !flush;
    assign busy        = (state != IDLE);
    assign bus_reqcyc  = reqcyc_q;
    assign bus_req     = reqcyc_q ? BUS_DATA_WIDTH'(addr_q) : '0;
    assign bus_reqtag  = reqcyc_q ? BUS_TAG_WIDTH'(FETCH_REQTAG) : '0;
    assign bus_respack = beat_en;
    assign line_valid  = line_valid_q;
    assign line_addr   = addr_q;

    line_assembler #(
        .BEAT_WIDTH(BUS_DATA_WIDTH),
        .BEATS     (BEATS)
    ) u_assembler (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .beat_en  (beat_en),
        .store_en (store_en),
        .beat_data(bus_resp),
        .line     (line_data),
        .last_beat(last_beat)
    );

    // flush outranks every other event; a flushed transfer whose request was
    // already accepted by the bus must still drain all its beats.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            reqcyc_q     <= 1'b0;
            line_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        addr_q   <= aligned_addr;
                        reqcyc_q <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        reqcyc_q <= 1'b0;
                        state    <= bus_reqack ? DRAIN : IDLE;
                    end else if (bus_reqack) begin
                        reqcyc_q <= 1'b0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    // A flush landing on the final beat completes the transfer, nothing left to drain.
                    if (last_beat) begin
                        line_valid_q <= !flush;
                        state        <= flush ? IDLE : HOLD;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (flush || line_ready) begin
                        line_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                DRAIN: begin
                    if (last_beat) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    reqcyc_q     <= 1'b0;
                    line_valid_q <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_line_fetch.sv
// Randomised scoreboard bench for sysbus_line_fetch, plus a narrow-line
// instance exercising the 128-bit bus / 32-byte line configuration.
module tb_sysbus_line_fetch;

    typedef struct {
        logic [63:0]  addr;
        logic [511:0] data;
    } line_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [63:0]  req_addr = '0;
    logic         flush = 1'b0;
    logic         line_valid;
    logic         line_ready = 1'b0;
    logic [63:0]  line_addr;
    logic [511:0] line_data;
    logic         busy;
    logic         bus_reqcyc;
    logic [63:0]  bus_req;
    logic [12:0]  bus_reqtag;
    logic         bus_reqack = 1'b0;
    logic         bus_respcyc = 1'b0;
    logic [63:0]  bus_resp = '0;
    logic [12:0]  bus_resptag = '0;
    logic         bus_respack;

    logic         p_req_valid = 1'b0;
    logic         p_req_ready;
    logic [63:0]  p_req_addr = '0;
    logic         p_flush = 1'b0;
    logic         p_line_valid;
    logic         p_line_ready = 1'b0;
    logic [63:0]  p_line_addr;
    logic [255:0] p_line_data;
    logic         p_busy;
    logic         p_bus_reqcyc;
    logic [127:0] p_bus_req;
    logic [12:0]  p_bus_reqtag;
    logic         p_bus_reqack = 1'b0;
    logic         p_bus_respcyc = 1'b0;
    logic [127:0] p_bus_resp = '0;
    logic [12:0]  p_bus_resptag = '0;
    logic         p_bus_respack;

    int    checks = 0;
    int    errors = 0;
    line_t exp_q[$];

    always #5 clk = ~clk;

    sysbus_line_fetch dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .line_valid(line_valid), .line_ready(line_ready),
        .line_addr(line_addr), .line_data(line_data),
        .busy(busy),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    sysbus_line_fetch #(
        .BUS_DATA_WIDTH(128),
        .BUS_TAG_WIDTH (13),
        .ADDR_WIDTH    (64),
        .LINE_BYTES    (32)
    ) dut_wide (
        .clk(clk), .reset(reset),
        .req_valid(p_req_valid), .req_ready(p_req_ready), .req_addr(p_req_addr),
        .flush(p_flush),
        .line_valid(p_line_valid), .line_ready(p_line_ready),
        .line_addr(p_line_addr), .line_data(p_line_data),
        .busy(p_busy),
        .bus_reqcyc(p_bus_reqcyc), .bus_req(p_bus_req), .bus_reqtag(p_bus_reqtag),
        .bus_reqack(p_bus_reqack),
        .bus_respcyc(p_bus_respcyc), .bus_resp(p_bus_resp), .bus_resptag(p_bus_resptag),
        .bus_respack(p_bus_respack)
    );

    task automatic check_output(input string name, input logic [511:0] actual,
                                input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every line handshake and checks that a held line stays put.
    initial begin
        line_t exp;
        logic  held = 1'b0;
        line_t held_line;
        forever begin
            @(negedge clk);
            #4;
            if (held && line_valid) begin
                check_output("hold_addr_stable", line_addr, held_line.addr);
                check_output("hold_data_stable", line_data, held_line.data);
            end
            held = 1'b0;
            if (line_valid && line_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_line", 1'b1, 1'b0);
                end else begin
                    exp = exp_q.pop_front();
                    check_output("line_addr", line_addr, exp.addr);
                    check_output("line_data", line_data, exp.data);
                end
            end else if (line_valid) begin
                held           = 1'b1;
                held_line.addr = line_addr;
                held_line.data = line_data;
            end
        end
    end

    // mode: 0 normal, 1 flush in REQ before ack, 2 flush with reqack,
    // 3 flush on beat flush_beat, 4 flush while the line is held.
    task automatic apply_stimulus(input logic [63:0] addr, input int mode, input int flush_beat,
                                  input int gap_pct, input int ack_delay, input int hold_cycles);
        logic [63:0]  beats[8];
        line_t        exp;
        int           waited;
        int           k;
        int           cyc;
        int           latency;
        exp.addr = (addr / 64) * 64;
        for (int i = 0; i < 8; i++) begin
            beats[i] = {$urandom, $urandom};
            exp.data[i*64 +: 64] = beats[i];
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check_output("req_ready_accept", req_ready, 1'b1);
        if (mode == 0) exp_q.push_back(exp);
        @(negedge clk);
        req_valid = 1'b0;
        latency = 1;
        #1;
        check_output("bus_reqcyc", bus_reqcyc, 1'b1);
        check_output("bus_req", bus_req, exp.addr);
        check_output("bus_reqtag", bus_reqtag, 13'h1100);
        check_output("busy_req", busy, 1'b1);
        check_output("req_ready_busy", req_ready, 1'b0);
        if (mode == 1) begin
            flush = 1'b1;
            bus_respcyc = 1'($urandom_range(0, 1));
            #1;
            check_output("respack_in_req", bus_respack, 1'b0);
            @(negedge clk);
            flush = 1'b0;
            bus_respcyc = 1'b0;
            #1;
            check_output("reqcyc_after_flush", bus_reqcyc, 1'b0);
            check_output("busy_after_flush", busy, 1'b0);
            check_output("req_ready_after_flush", req_ready, 1'b1);
            return;
        end
        for (int d = 0; d < ack_delay; d++) begin
            bus_respcyc = 1'($urandom_range(0, 1));
            #1;
            check_output("respack_in_req", bus_respack, 1'b0);
            @(negedge clk);
            bus_respcyc = 1'b0;
            latency++;
            #1;
            check_output("reqcyc_held", bus_reqcyc, 1'b1);
        end
        bus_reqack = 1'b1;
        if (mode == 2) flush = 1'b1;
        @(negedge clk);
        bus_reqack = 1'b0;
        flush = 1'b0;
        latency++;
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 200) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                bus_respcyc = 1'b0;
            end else begin
                bus_respcyc = 1'b1;
                bus_resp = beats[k];
                if (mode == 3 && k == flush_beat) flush = 1'b1;
            end
            #1;
            check_output("respack_follows_respcyc", bus_respack, bus_respcyc);
            check_output("no_line_during_beats", line_valid, 1'b0);
            if (bus_respcyc) k++;
            @(negedge clk);
            bus_respcyc = 1'b0;
            flush = 1'b0;
            latency++;
            cyc++;
        end
        check_output("beats_delivered", 32'(k), 32'd8);
        #1;
        if (mode == 0 || mode == 4) begin
            check_output("line_valid_hold", line_valid, 1'b1);
            check_output("line_addr_hold", line_addr, exp.addr);
            check_output("req_ready_hold", req_ready, 1'b0);
            if (gap_pct == 0 && ack_delay == 0) begin
                check_output("min_latency", 32'(latency), 32'd10);
            end
            for (int h = 0; h < hold_cycles; h++) begin
                bus_respcyc = 1'($urandom_range(0, 1));
                #1;
                check_output("respack_in_hold", bus_respack, 1'b0);
                check_output("req_ready_hold", req_ready, 1'b0);
                @(negedge clk);
                bus_respcyc = 1'b0;
                #1;
                check_output("line_valid_held", line_valid, 1'b1);
            end
            if (mode == 4) flush = 1'b1;
            else line_ready = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            line_ready = 1'b0;
            #1;
        end
        check_output("line_valid_idle", line_valid, 1'b0);
        check_output("busy_idle", busy, 1'b0);
        check_output("req_ready_idle", req_ready, 1'b1);
    endtask

    task automatic run_flush_idle;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = {$urandom, $urandom};
        flush     = 1'b1;
        #1;
        check_output("req_ready_flush_idle", req_ready, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        check_output("busy_flush_idle", busy, 1'b0);
        check_output("reqcyc_flush_idle", bus_reqcyc, 1'b0);
    endtask

    task automatic run_wide;
        logic [127:0] b0;
        logic [127:0] b1;
        b0 = {$urandom, $urandom, $urandom, $urandom};
        b1 = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        p_req_valid = 1'b1;
        p_req_addr  = 64'h2F;
        #1;
        check_output("wide_req_ready", p_req_ready, 1'b1);
        @(negedge clk);
        p_req_valid = 1'b0;
        #1;
        check_output("wide_bus_req", p_bus_req, 128'h20);
        check_output("wide_reqcyc", p_bus_reqcyc, 1'b1);
        p_bus_reqack = 1'b1;
        @(negedge clk);
        p_bus_reqack  = 1'b0;
        p_bus_respcyc = 1'b1;
        p_bus_resp    = b0;
        @(negedge clk);
        p_bus_resp    = b1;
        @(negedge clk);
        p_bus_respcyc = 1'b0;
        #1;
        check_output("wide_line_valid", p_line_valid, 1'b1);
        check_output("wide_line_addr", p_line_addr, 64'h20);
        check_output("wide_line_data", p_line_data, {b1, b0});
        p_line_ready = 1'b1;
        @(negedge clk);
        p_line_ready = 1'b0;
        #1;
        check_output("wide_line_taken", p_line_valid, 1'b0);
        check_output("wide_busy", p_busy, 1'b0);
    endtask

    task automatic run_reset_mid;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = {$urandom, $urandom};
        @(negedge clk);
        req_valid  = 1'b0;
        bus_reqack = 1'b1;
        @(negedge clk);
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b1;
        bus_resp    = {$urandom, $urandom};
        @(negedge clk);
        bus_resp = {$urandom, $urandom};
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("respack_before_reset_edge", bus_respack, 1'b1);
        @(negedge clk);
        #1;
        check_output("rst_req_ready", req_ready, 1'b1);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_line_valid", line_valid, 1'b0);
        check_output("rst_reqcyc", bus_reqcyc, 1'b0);
        check_output("rst_respack_stray", bus_respack, 1'b0);
        check_output("rst_line_addr", line_addr, 64'h0);
        check_output("rst_line_data", line_data, 512'h0);
        reset = 1'b1;
        bus_respcyc = 1'b0;
        @(negedge clk);
        #1;
        check_output("rst_release_busy", busy, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_output("init_req_ready", req_ready, 1'b1);
        check_output("init_busy", busy, 1'b0);
        check_output("init_line_valid", line_valid, 1'b0);
        check_output("init_reqcyc", bus_reqcyc, 1'b0);
        check_output("init_bus_req", bus_req, 64'h0);
        check_output("init_line_data", line_data, 512'h0);
        reset = 1'b1;

        apply_stimulus(64'h1000_0014, 0, 0, 0, 0, 0);
        apply_stimulus({$urandom, $urandom}, 0, 0, 50, 1, 5);
        apply_stimulus({$urandom, $urandom}, 3, 3, 0, 0, 0);
        apply_stimulus({$urandom, $urandom}, 1, 0, 0, 0, 0);
        apply_stimulus({$urandom, $urandom}, 2, 0, 30, 0, 0);
        apply_stimulus({$urandom, $urandom}, 4, 0, 0, 2, 3);
        run_flush_idle();
        run_wide();

        for (int n = 0; n < 40; n++) begin
            int sel;
            int mode;
            sel  = $urandom_range(0, 9);
            mode = (sel <= 5) ? 0 : sel - 5;
            apply_stimulus({$urandom, $urandom}, mode, $urandom_range(0, 6),
                           $urandom_range(0, 50), $urandom_range(0, 2), $urandom_range(0, 4));
        end

        run_reset_mid();
        apply_stimulus({$urandom, $urandom}, 0, 0, 20, 1, 1);

        repeat (3) @(negedge clk);
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
